dmem_ctrl: RTL and testbench

//  Sequences and shares the word-indexed data memory between two requesters: port 0 (core LSU) and port 1 (DMA/loader).

---
 rtl/dmem_pkg.sv | 50 +++++
 rtl/dmem_lane.sv | 42 ++++
 rtl/dmem_ctrl.sv | 168 ++++++++++++++++
 tb/tb_dmem_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory controller.
// State encoding, funct3 constants, lane pickers and access checks.
package dmem_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_MERGE,
      S_DONE
   } state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   function automatic logic [7:0] pick_byte(
      input logic [31:0] w,
      input logic [1:0]  off
   );
      return w[8*off +: 8];
   endfunction

   function automatic logic [15:0] pick_half(
      input logic [31:0] w,
      input logic        hi
   );
      return hi ? w[31:16] : w[15:0];
   endfunction

   // Rejects misaligned, illegal-width and out-of-range accesses.
   function automatic logic access_err(
      input logic        we,
      input logic [2:0]  f3,
      input logic [31:0] addr,
      input logic [31:0] words
   );
      logic bad_f3;
      logic mis;
      logic range;
      bad_f3 = (f3 == 3'b011) || (f3 == 3'b110) ||
               (f3 == 3'b111) || (we && f3[2]);
      mis    = ((f3 == F3_H || f3 == F3_HU) && addr[0]) ||
               ((f3 == F3_W) && (addr[1:0] != 2'b00));
      range  = {2'b00, addr[31:2]} >= words;
      return bad_f3 || mis || range;
   endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte/halfword lane logic for the data-memory controller.
// Load extract with sign/zero extension and store merge.
module dmem_lane
   import dmem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merge_data
);

   logic [7:0]  b;
   logic [15:0] h;

   assign b = pick_byte(word, off);
   assign h = pick_half(word, off[1]);

   // Select and extend the addressed lane for loads.
   always_comb begin
      load_data = word;
      case (funct3)
         F3_B:    load_data = {{24{b[7]}}, b};
         F3_BU:   load_data = {24'h0, b};
         F3_H:    load_data = {{16{h[15]}}, h};
         F3_HU:   load_data = {16'h0, h};
         default: load_data = word;
      endcase
   end

   // Replace the addressed lane of the old word with store data.
   always_comb begin
      merge_data = word;
      case (funct3[1:0])
         2'b00:   merge_data[8*off +: 8] = wdata[7:0];
         2'b01:   merge_data[16*off[1] +: 16] = wdata[15:0];
         default: merge_data = wdata;
      endcase
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Two-port round-robin data-memory controller.
// One access in flight; sub-word stores use read-modify-write.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int MEM_WORDS = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        r0_req,
   input  logic        r0_we,
   input  logic [2:0]  r0_funct3,
   input  logic [31:0] r0_addr,
   input  logic [31:0] r0_wdata,
   output logic        r0_gnt,
   output logic        r0_rvalid,
   output logic [31:0] r0_rdata,
   output logic        r0_err,
   input  logic        r1_req,
   input  logic        r1_we,
   input  logic [2:0]  r1_funct3,
   input  logic [31:0] r1_addr,
   input  logic [31:0] r1_wdata,
   output logic        r1_gnt,
   output logic        r1_rvalid,
   output logic [31:0] r1_rdata,
   output logic        r1_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_data_write,
   output logic        mem_enable,
   output logic        mem_read_write,
   input  logic [31:0] mem_data_read
);

   localparam logic [31:0] WORDS = 32'(MEM_WORDS);

   state_t      state;
   state_t      state_nx;
   logic        rr_ptr;
   logic        owner;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        err_q;
   logic [31:0] resp_q;
   logic [31:0] merge_q;

   logic        any;
   logic        sel;
   logic        grant;
   logic        g_we;
   logic [2:0]  g_f3;
   logic [31:0] g_addr;
   logic [31:0] g_wdata;
   logic        g_err;
   logic        word_st;
   logic        done;
   logic [31:0] lane_word;
   logic [31:0] load_data;
   logic [31:0] merge_data;

   // Round-robin winner selection and granted request fields.
   always_comb begin
      any     = r0_req | r1_req;
      sel     = rr_ptr ? r1_req : ~r0_req;
      grant   = (state == S_IDLE) && any && !rst;
      g_we    = sel ? r1_we     : r0_we;
      g_f3    = sel ? r1_funct3 : r0_funct3;
      g_addr  = sel ? r1_addr   : r0_addr;
      g_wdata = sel ? r1_wdata  : r0_wdata;
      g_err   = access_err(g_we, g_f3, g_addr, WORDS);
   end

   assign r0_gnt  = grant & ~sel;
   assign r1_gnt  = grant & sel;
   assign word_st = we_q && (f3_q[1:0] == 2'b10);

   assign lane_word = (state == S_MERGE) ? merge_q : mem_data_read;

   dmem_lane u_lane (
      .word       (lane_word),
      .off        (addr_q[1:0]),
      .funct3     (f3_q),
      .wdata      (wdata_q),
      .load_data  (load_data),
      .merge_data (merge_data)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // Next state and memory strobes; reset blocks any write.
   always_comb begin
      state_nx       = state;
      mem_enable     = 1'b0;
      mem_read_write = 1'b0;
      mem_data_write = 32'h0;
      unique case (state)
         S_IDLE: begin
            if (grant) state_nx = g_err ? S_DONE : S_ACCESS;
         end
         S_ACCESS: begin
            mem_enable     = 1'b1;
            mem_read_write = word_st;
            mem_data_write = word_st ? wdata_q : 32'h0;
            state_nx       = (we_q && !word_st) ? S_MERGE : S_DONE;
         end
         S_MERGE: begin
            mem_enable     = 1'b1;
            mem_read_write = 1'b1;
            mem_data_write = merge_data;
            state_nx       = S_DONE;
         end
         S_DONE: begin
            state_nx = S_IDLE;
         end
      endcase
      if (rst) begin
         mem_enable     = 1'b0;
         mem_read_write = 1'b0;
         mem_data_write = 32'h0;
      end
   end

   // Request latch, arbitration pointer and response capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr  <= 1'b0;
         owner   <= 1'b0;
         we_q    <= 1'b0;
         f3_q    <= 3'b000;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         err_q   <= 1'b0;
         resp_q  <= 32'h0;
         merge_q <= 32'h0;
      end else begin
         if (grant) begin
            owner   <= sel;
            rr_ptr  <= ~sel;
            we_q    <= g_we;
            f3_q    <= g_f3;
            addr_q  <= g_addr;
            wdata_q <= g_wdata;
            err_q   <= g_err;
            resp_q  <= 32'h0;
         end
         if (state == S_ACCESS) begin
            merge_q <= mem_data_read;
            if (!we_q) resp_q <= load_data;
         end
      end
   end

   assign mem_addr  = {2'b00, addr_q[31:2]};
   assign done      = (state == S_DONE);
   assign r0_rvalid = done & ~owner;
   assign r1_rvalid = done & owner;
   assign r0_rdata  = r0_rvalid ? resp_q : 32'h0;
   assign r1_rdata  = r1_rvalid ? resp_q : 32'h0;
   assign r0_err    = r0_rvalid & err_q;
   assign r1_err    = r1_rvalid & err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl with a behavioural memory.
// Drivers push expected responses at grant; a monitor pops on rvalid.
module tb_dmem_ctrl;
   import dmem_pkg::*;

   localparam int MW = 1000;

   logic        clk = 1'b0;
   logic        rst;
   logic        r0_req, r0_we, r1_req, r1_we;
   logic [2:0]  r0_funct3, r1_funct3;
   logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
   logic        r0_gnt, r0_rvalid, r0_err;
   logic        r1_gnt, r1_rvalid, r1_err;
   logic [31:0] r0_rdata, r1_rdata;
   logic [31:0] mem_addr, mem_data_write, mem_data_read;
   logic        mem_enable, mem_read_write;

   logic [31:0] mem [0:1023];

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          due;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   glog[$];
   logic log_on = 1'b0;
   int   en_cnt = 0;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   always #5 clk = ~clk;

   dmem_ctrl #(.MEM_WORDS(MW)) dut (
      .clk(clk), .rst(rst),
      .r0_req(r0_req), .r0_we(r0_we), .r0_funct3(r0_funct3),
      .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_gnt(r0_gnt),
      .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_err(r0_err),
      .r1_req(r1_req), .r1_we(r1_we), .r1_funct3(r1_funct3),
      .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_gnt(r1_gnt),
      .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_err(r1_err),
      .mem_addr(mem_addr), .mem_data_write(mem_data_write),
      .mem_enable(mem_enable), .mem_read_write(mem_read_write),
      .mem_data_read(mem_data_read)
   );

   assign mem_data_read = (mem_addr < 32'd1024) ? mem[mem_addr[9:0]] : 32'h0;

   always @(posedge clk) begin
      if (mem_enable && mem_read_write && mem_addr < 32'd1024)
         mem[mem_addr[9:0]] <= mem_data_write;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic mon_port(input int p, input logic [31:0] rd,
                           input logic er);
      exp_t e;
      if ((p == 0 ? q0.size() : q1.size()) == 0) begin
         checks++;
         errors++;
         $display("FAIL r%0d_unexpected_rvalid actual=1 expected=0", p);
      end else begin
         if (p == 0) e = q0.pop_front();
         else        e = q1.pop_front();
         chk($sformatf("r%0d_rdata", p), rd, e.rdata);
         chk($sformatf("r%0d_err", p), {31'b0, er}, {31'b0, e.err});
         chk($sformatf("r%0d_latency", p), cyc, e.due);
      end
   endtask

   // Monitor: grant sanity, enable activity, response scoreboard.
   always @(negedge clk) begin
      if (r0_gnt || r1_gnt) begin
         chk("one_gnt", {31'b0, r0_gnt & r1_gnt}, 32'h0);
         if (log_on) glog.push_back(r1_gnt ? 1 : 0);
      end
      if (mem_enable) en_cnt++;
      if (r0_rvalid) mon_port(0, r0_rdata, r0_err);
      if (r1_rvalid) mon_port(1, r1_rdata, r1_err);
   end

   task automatic issue(input int p, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee,
                        input int lat, input logic exp_rsp);
      exp_t e;
      logic got;
      int   n;
      got = 1'b0;
      n = 0;
      if (p == 0) begin
         r0_req = 1'b1; r0_we = we; r0_funct3 = f3;
         r0_addr = a; r0_wdata = wd;
      end else begin
         r1_req = 1'b1; r1_we = we; r1_funct3 = f3;
         r1_addr = a; r1_wdata = wd;
      end
      while (!got && n < 60) begin
         @(negedge clk);
         n++;
         got = (p == 0) ? r0_gnt : r1_gnt;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL r%0d_gnt_timeout actual=0 expected=1", p);
      end else if (exp_rsp) begin
         e.rdata = er;
         e.err   = ee;
         e.due   = cyc + lat;
         if (p == 0) q0.push_back(e);
         else        q1.push_back(e);
      end
      @(posedge clk);
      #1;
      if (p == 0) r0_req = 1'b0;
      else        r1_req = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q0.size() + q1.size()) != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      chk("drain", q0.size() + q1.size(), 32'h0);
   endtask

   initial begin
      rst = 1'b1;
      r0_req = 1'b0; r0_we = 1'b0; r0_funct3 = 3'b0;
      r0_addr = 32'h0; r0_wdata = 32'h0;
      r1_req = 1'b0; r1_we = 1'b0; r1_funct3 = 3'b0;
      r1_addr = 32'h0; r1_wdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_enable", {31'b0, mem_enable}, 32'h0);
      chk("rst_wdata", mem_data_write, 32'h0);
      chk("rst_rvalid", {30'b0, r1_rvalid, r0_rvalid}, 32'h0);
      chk("rst_addr", mem_addr, 32'h0);
      rst = 1'b0;

      // Word store then load.
      issue(0, 1, F3_W, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2, 1);
      issue(0, 0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2, 1);
      drain();
      chk("mem4_sw", mem[4], 32'hDEADBEEF);

      // Byte store read-modify-write, byte loads.
      issue(0, 1, F3_B, 32'h13, 32'h00000055, 32'h0, 0, 3, 1);
      issue(0, 0, F3_B, 32'h13, 32'h0, 32'h00000055, 0, 2, 1);
      issue(0, 0, F3_BU, 32'h12, 32'h0, 32'h000000AD, 0, 2, 1);
      issue(0, 0, F3_B, 32'h12, 32'h0, 32'hFFFFFFAD, 0, 2, 1);
      drain();
      chk("mem4_sb", mem[4], 32'h55ADBEEF);

      // Halfword loads from port 1, preload other words.
      issue(1, 1, F3_W, 32'h10, 32'h80001234, 32'h0, 0, 2, 1);
      issue(1, 0, F3_H, 32'h12, 32'h0, 32'hFFFF8000, 0, 2, 1);
      issue(1, 0, F3_HU, 32'h12, 32'h0, 32'h00008000, 0, 2, 1);
      issue(1, 0, F3_H, 32'h10, 32'h0, 32'h00001234, 0, 2, 1);
      issue(1, 1, F3_W, 32'h20, 32'h11223344, 32'h0, 0, 2, 1);
      issue(1, 1, F3_W, 32'h00, 32'hCAFEF00D, 32'h0, 0, 2, 1);
      issue(1, 1, F3_H, 32'h02, 32'h7777A5A5, 32'h0, 0, 3, 1);
      issue(1, 0, F3_W, 32'h00, 32'h0, 32'hA5A5F00D, 0, 2, 1);
      issue(0, 1, F3_W, 32'(4*MW-4), 32'h0BADF00D, 32'h0, 0, 2, 1);
      issue(0, 0, F3_W, 32'(4*MW-4), 32'h0, 32'h0BADF00D, 0, 2, 1);
      drain();

      // Error paths: no memory access at all.
      en_cnt = 0;
      issue(0, 0, F3_W, 32'h11, 32'h0, 32'h0, 1, 1, 1);
      issue(0, 1, F3_H, 32'h01, 32'h1234, 32'h0, 1, 1, 1);
      issue(0, 0, F3_W, 32'(4*MW), 32'h0, 32'h0, 1, 1, 1);
      issue(0, 0, 3'b011, 32'h10, 32'h0, 32'h0, 1, 1, 1);
      issue(1, 1, F3_BU, 32'h10, 32'hFF, 32'h0, 1, 1, 1);
      drain();
      chk("err_no_enable", en_cnt, 32'h0);
      chk("mem4_untouched", mem[4], 32'h80001234);

      // Reset during the merge cycle of a byte store.
      issue(0, 1, F3_B, 32'h20, 32'h00000099, 32'h0, 0, 3, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_merge_enable", {31'b0, mem_enable}, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("mem8_after_rst", mem[8], 32'h11223344);
      repeat (4) @(posedge clk);
      #1;

      // Both ports contend; port 0 must win first after reset.
      glog.delete();
      log_on = 1'b1;
      fork
         begin
            issue(0, 0, F3_W, 32'h00, 32'h0, 32'hA5A5F00D, 0, 2, 1);
            issue(0, 0, F3_W, 32'h10, 32'h0, 32'h80001234, 0, 2, 1);
         end
         begin
            issue(1, 0, F3_W, 32'h20, 32'h0, 32'h11223344, 0, 2, 1);
            issue(1, 0, F3_W, 32'h00, 32'h0, 32'hA5A5F00D, 0, 2, 1);
         end
      join
      drain();
      log_on = 1'b0;
      chk("gnt_count", glog.size(), 32'd4);
      for (int i = 0; i < glog.size(); i++)
         chk($sformatf("gnt_order_%0d", i), glog[i], i % 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
